// File: rtl/accum_column_array.sv
// Multi-column signed partial-sum accumulator with a 2-stage RMW pipeline, S2 forwarding,
// sweep-clear FSM and registered readout. Define ACC_SAT_EN for saturating accumulate.
module accum_column_array #(
    parameter int unsigned NUM_COLS = 16,
    parameter int unsigned DEPTH    = 12,
    parameter int unsigned IN_W     = 24,
    parameter int unsigned ACC_W    = 32,
    // derived row-address width; leave at default
    parameter int unsigned ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ADDR_W-1:0]           in_addr,
    input  logic                        in_acc,
    input  logic [NUM_COLS*IN_W-1:0]    in_psum,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic                        rd_valid,
    output logic [NUM_COLS*ACC_W-1:0]   rd_data,
    input  logic                        clr_start,
    output logic                        busy,
    output logic [NUM_COLS-1:0]         sat_flag
);

    localparam int unsigned ROW_W = NUM_COLS * ACC_W;
    localparam int unsigned PSUM_W = NUM_COLS * IN_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    logic [1:0]          state, state_nxt;
    logic [ADDR_W-1:0]   ctr, ctr_nxt;

    logic                s1_valid;
    logic [ADDR_W-1:0]   s1_addr;
    logic                s1_acc;
    logic [PSUM_W-1:0]   s1_psum;
    logic                s2_valid;
    logic [ADDR_W-1:0]   s2_addr;
    logic [ROW_W-1:0]    s2_data;

    logic [ROW_W-1:0]    mem [DEPTH];
    logic [ROW_W-1:0]    old_row, new_row, rd_row;
    logic                accept;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W+1)'(DEPTH);
    endfunction

    assign accept = in_valid & in_ready;

    // Next-state logic: drain the pipeline before sweeping so no late write lands on a cleared row
    always_comb begin
        state_nxt = state;
        ctr_nxt   = ctr;
        case (state)
            ST_IDLE: begin
                if (clr_start) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!s1_valid && !s2_valid) begin
                    state_nxt = ST_CLEAR;
                    ctr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (ctr == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = ST_IDLE;
                    ctr_nxt   = '0;
                end else begin
                    ctr_nxt = ctr + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                ctr_nxt   = '0;
            end
        endcase
    end

    // Old row for RMW: S2 result takes priority over the not-yet-written memory copy
    always_comb begin
        old_row = '0;
        if (s2_valid && s2_addr == s1_addr) old_row = s2_data;
        else if (in_range(s1_addr))         old_row = mem[s1_addr];
    end

    always_comb begin
        rd_row = '0;
        if (!in_range(rd_addr))                     rd_row = '0;
        else if (s2_valid && s2_addr == rd_addr)    rd_row = s2_data;
        else                                        rd_row = mem[rd_addr];
    end

`ifdef ACC_SAT_EN
    logic [NUM_COLS-1:0] sat_lane;
`endif

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
        logic signed [IN_W-1:0]  psum;
        logic signed [ACC_W-1:0] old_v, psum_x, new_v;
        assign psum   = s1_psum[c*IN_W +: IN_W];
        assign old_v  = old_row[c*ACC_W +: ACC_W];
        assign psum_x = ACC_W'(psum);
`ifdef ACC_SAT_EN
        logic signed [ACC_W:0] sum;
        assign sum         = (ACC_W+1)'(old_v) + (ACC_W+1)'(psum_x);
        assign sat_lane[c] = s1_acc && (sum[ACC_W] != sum[ACC_W-1]);
        always_comb begin
            if (!s1_acc)          new_v = psum_x;
            else if (sat_lane[c]) new_v = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                     : {1'b0, {(ACC_W-1){1'b1}}};
            else                  new_v = sum[ACC_W-1:0];
        end
`else
        assign new_v = s1_acc ? old_v + psum_x : psum_x;
`endif
        assign new_row[c*ACC_W +: ACC_W] = new_v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_CLEAR;
            ctr      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_acc   <= 1'b0;
            s1_psum  <= '0;
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_data  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nxt;
            ctr      <= ctr_nxt;
            in_ready <= (state_nxt == ST_IDLE);
            busy     <= (state_nxt != ST_IDLE);
            // out-of-range rows are dropped at the door
            s1_valid <= accept && in_range(in_addr);
            if (accept) begin
                s1_addr <= in_addr;
                s1_acc  <= in_acc;
                s1_psum <= in_psum;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_addr <= s1_addr;
                s2_data <= new_row;
            end
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_row;
        end
    end

    // LUTRAM write port: sweep row or retiring S2 result (never both, S2 is empty while clearing)
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR)  mem[ctr]     <= '0;
        else if (s2_valid)      mem[s2_addr] <= s2_data;
    end

`ifdef ACC_SAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   sat_flag <= '0;
        else if (state == ST_CLEAR) sat_flag <= '0;
        else if (s1_valid)         sat_flag <= sat_flag | sat_lane;
    end
`else
    assign sat_flag = '0;
`endif

endmodule

// File: tb/tb_accum_column_array.sv
// Directed bench for accum_column_array: reset sweep, forwarding, readout timing,
// overflow behaviour, drain-then-clear and reset during a sweep.
module tb_accum_column_array;

    localparam int unsigned NUM_COLS = 16;
    localparam int unsigned DEPTH    = 12;
    localparam int unsigned IN_W     = 24;
    localparam int unsigned ACC_W    = 32;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned PW       = NUM_COLS * IN_W;
    localparam int unsigned RW       = NUM_COLS * ACC_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [ADDR_W-1:0]    in_addr;
    logic                 in_acc;
    logic [PW-1:0]        in_psum;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_valid;
    logic [RW-1:0]        rd_data;
    logic                 clr_start;
    logic                 busy;
    logic [NUM_COLS-1:0]  sat_flag;

    int tests = 0;
    int fails = 0;
    int n;
    logic [ACC_W-1:0]    ovf_val;
    logic [NUM_COLS-1:0] ovf_sat;

    accum_column_array #(
        .NUM_COLS(NUM_COLS), .DEPTH(DEPTH), .IN_W(IN_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_acc(in_acc), .in_psum(in_psum),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .clr_start(clr_start), .busy(busy), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] p_all(input logic [IN_W-1:0] v);
        logic [PW-1:0] p;
        for (int c = 0; c < NUM_COLS; c++) p[c*IN_W +: IN_W] = v;
        return p;
    endfunction

    function automatic logic [PW-1:0] p_lane0(input logic [IN_W-1:0] v);
        logic [PW-1:0] p;
        p = '0;
        p[IN_W-1:0] = v;
        return p;
    endfunction

    function automatic logic [RW-1:0] a_all(input logic [ACC_W-1:0] v);
        logic [RW-1:0] r;
        for (int c = 0; c < NUM_COLS; c++) r[c*ACC_W +: ACC_W] = v;
        return r;
    endfunction

    function automatic logic [RW-1:0] a_lane0(input logic [ACC_W-1:0] v);
        logic [RW-1:0] r;
        r = '0;
        r[ACC_W-1:0] = v;
        return r;
    endfunction

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic [ADDR_W-1:0] a, input logic acc, input logic [PW-1:0] p);
        in_valid = 1'b1;
        in_addr  = a;
        in_acc   = acc;
        in_psum  = p;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [RW-1:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en   = 1'b0;
        check({tag, "_valid"}, RW'(rd_valid), RW'(1'b1));
        check(tag, rd_data, exp);
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (in_ready !== 1'b1 && cycles < 200) begin
            step();
            cycles++;
        end
    endtask

    initial begin
`ifdef ACC_SAT_EN
        ovf_val = 32'h7FFF_FFFF;
        ovf_sat = '1;
`else
        ovf_val = 32'h8000_0000;
        ovf_sat = '0;
`endif
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_acc = 1'b0; in_psum = '0;
        rd_en = 1'b0; rd_addr = '0; clr_start = 1'b0;
        repeat (3) step();

        // reset values
        check("rst_in_ready", RW'(in_ready), RW'(1'b0));
        check("rst_busy",     RW'(busy),     RW'(1'b1));
        check("rst_rd_valid", RW'(rd_valid), RW'(1'b0));
        check("rst_rd_data",  rd_data,       '0);
        check("rst_sat_flag", RW'(sat_flag), '0);

        // automatic sweep after release: one row per cycle
        rst = 1'b0;
        wait_ready(n);
        check("init_sweep_len", RW'(n), RW'(DEPTH));
        check("init_busy_low",  RW'(busy), RW'(1'b0));
        for (int r = 0; r < int'(DEPTH); r++) do_read(ADDR_W'(r), '0, "init_row_zero");

        // overwrite 5 then accumulate -7 back-to-back on row 3
        drive_wr(4'd3, 1'b0, p_lane0(24'd5));
        step();
        drive_wr(4'd3, 1'b1, p_lane0(24'hFFFFF9));
        step();
        in_valid = 1'b0;
        step();
        do_read(4'd3, a_lane0(32'hFFFF_FFFE), "fwd_row3");

        // four consecutive +1 accumulates on row 1, read 2 cycles after last accept
        drive_wr(4'd1, 1'b1, p_all(24'd1));
        repeat (4) step();
        in_valid = 1'b0;
        step();
        do_read(4'd1, a_all(32'd4), "acc4_row1");
        step();
        check("rd_valid_pulse", RW'(rd_valid), RW'(1'b0));
        check("rd_data_hold",   rd_data,       a_all(32'd4));

        // write still in S1 is not visible to a read issued the next cycle
        drive_wr(4'd1, 1'b1, p_all(24'd1));
        step();
        in_valid = 1'b0;
        do_read(4'd1, a_all(32'd4), "s1_excluded");
        do_read(4'd1, a_all(32'd5), "s1_landed");

        // out-of-range row: write dropped, read returns zero
        drive_wr(4'd13, 1'b0, p_all(24'd7));
        step();
        in_valid = 1'b0;
        repeat (2) step();
        do_read(4'd13, '0, "oor_read13");
        do_read(4'd15, '0, "oor_read15");
        do_read(4'd1, a_all(32'd5), "oor_no_alias");

        // build 2^31-1 on row 2: (2^23-1)*256 + 255, then push past the top
        drive_wr(4'd2, 1'b0, p_all(24'h7FFFFF));
        step();
        in_acc = 1'b1;
        repeat (255) step();
        in_psum = p_all(24'h0000FF);
        step();
        in_valid = 1'b0;
        step();
        do_read(4'd2, a_all(32'h7FFF_FFFF), "max_row2");
        check("sat_before_ovf", RW'(sat_flag), '0);
        drive_wr(4'd2, 1'b1, p_all(24'd1));
        step();
        in_valid = 1'b0;
        step();
        do_read(4'd2, a_all(ovf_val), "ovf_row2");
        check("sat_after_ovf", RW'(sat_flag), RW'(ovf_sat));

        // clear requested with S1 and S2 occupied: pending writes land, then sweep
        drive_wr(4'd5, 1'b0, p_all(24'd9));
        step();
        drive_wr(4'd6, 1'b0, p_all(24'd11));
        clr_start = 1'b1;
        step();
        in_valid = 1'b0;
        clr_start = 1'b0;
        check("drain_in_ready", RW'(in_ready), RW'(1'b0));
        check("drain_busy",     RW'(busy),     RW'(1'b1));
        do_read(4'd5, a_all(32'd9),  "drain_row5");
        do_read(4'd6, a_all(32'd11), "drain_row6");
        wait_ready(n);
        check("clr_done",     RW'(n < 200), RW'(1'b1));
        check("clr_busy_low", RW'(busy),     RW'(1'b0));
        check("clr_sat",      RW'(sat_flag), '0);
        do_read(4'd5, '0, "clr_row5");
        do_read(4'd6, '0, "clr_row6");
        do_read(4'd2, '0, "clr_row2");

        // reset while the sweep is at row 5
        drive_wr(4'd7, 1'b0, p_all(24'h123456));
        step();
        in_valid = 1'b0;
        repeat (2) step();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        step();
        do_read(4'd7, a_all(32'h0012_3456), "clear_rd_row7");
        repeat (4) step();
        check("mid_clear_busy", RW'(busy), RW'(1'b1));
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", RW'(in_ready), RW'(1'b0));
        check("mid_rst_busy",     RW'(busy),     RW'(1'b1));
        check("mid_rst_rd_valid", RW'(rd_valid), RW'(1'b0));
        check("mid_rst_rd_data",  rd_data,       '0);
        check("mid_rst_sat_flag", RW'(sat_flag), '0);
        step();
        step();
        rst = 1'b0;
        wait_ready(n);
        check("restart_sweep_len", RW'(n), RW'(DEPTH));
        do_read(4'd7, '0, "restart_row7");
        do_read(4'd0, '0, "restart_row0");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
